// File: rtl/axi4_mem_rd_ctrl.sv
// AXI4 read-channel front-end for a 1024x32 on-chip memory.
// One AR burst at a time is split into single-word memory reads. Beats go
// through a 1-cycle read pipe into a 2-entry first-word-fall-through buffer
// that drives the R channel. Error beats (bad size/burst, or out of range)
// follow the same pipe so that beat order is preserved.
module axi4_mem_rd_ctrl #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [2:0]                ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      mem_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  // One spare address bit so a burst running past the top of the AXI
  // address space keeps counting upward instead of wrapping back into range.
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES  = AW1'(MEM_DEPTH * 4);
  localparam logic [ADDR_WIDTH:0] WORD_MASK  = ~AW1'(3);
  localparam logic [ADDR_WIDTH:0] WORD_BYTES = AW1'(4);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  fixed_q, fixed_d;
  logic                  err_cfg_q, err_cfg_d;
  logic [8:0]            issued_q, issued_d;

  logic                  infl_q, infl_d;
  logic                  infl_err_q, infl_err_d;
  logic                  infl_last_q, infl_last_d;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_resp_q [2];
  logic                  buf_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  push_s, pop_s, issue_s, err_beat_s, head_last_s;
  logic [2:0]            occ_s, limit_s;

  // Buffer handshake and the "never overflow" issue gate: buffered plus
  // in-flight beats, net of this cycle's pop, must leave room for one more.
  assign push_s      = infl_q;
  assign pop_s       = (count_q != 2'd0) && RREADY;
  assign head_last_s = buf_last_q[rd_ptr_q];
  assign occ_s       = {1'b0, count_q} + {2'b00, infl_q};
  assign limit_s     = 3'd2 + {2'b00, pop_s};
  assign issue_s     = (state_q == ST_BURST) && (issued_q <= {1'b0, len_q}) && (occ_s < limit_s);
  assign err_beat_s  = err_cfg_q || (addr_q >= MEM_BYTES);

  assign ARREADY  = arready_q;
  assign mem_en   = issue_s && !err_beat_s;
  assign mem_addr = mem_en ? addr_q[MEM_ADDR_WIDTH+1:2] : {MEM_ADDR_WIDTH{1'b0}};
  assign RVALID   = (count_q != 2'd0);
  assign RDATA    = buf_data_q[rd_ptr_q];
  assign RRESP    = buf_resp_q[rd_ptr_q];
  assign RLAST    = RVALID && buf_last_q[rd_ptr_q];

  // Burst FSM: accept AR in IDLE, walk the beat address in BURST, leave on the last R handshake.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    addr_d    = addr_q;
    len_d     = len_q;
    fixed_d   = fixed_q;
    err_cfg_d = err_cfg_q;
    issued_d  = issued_q;
    case (state_q)
      ST_IDLE: begin
        if (ARVALID && arready_q) begin
          state_d   = ST_BURST;
          arready_d = 1'b0;
          addr_d    = {1'b0, ARADDR} & WORD_MASK;
          len_d     = ARLEN;
          fixed_d   = (ARBURST == 2'b00);
          err_cfg_d = (ARSIZE != 3'b010) || ARBURST[1];
          issued_d  = 9'd0;
        end else begin
          arready_d = 1'b1;
        end
      end
      ST_BURST: begin
        if (issue_s) begin
          issued_d = issued_q + 9'd1;
          if (!fixed_q) begin
            addr_d = addr_q + WORD_BYTES;
          end else begin
            addr_d = addr_q;
          end
        end else begin
          issued_d = issued_q;
        end
        if (pop_s && head_last_s) begin
          state_d   = ST_IDLE;
          arready_d = 1'b1;
        end else begin
          state_d   = ST_BURST;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arready_d = 1'b0;
      end
    endcase
  end

  // Read pipe tags: remember whether the beat issued this cycle is an error and/or the last one.
  always_comb begin
    infl_d      = issue_s;
    infl_err_d  = 1'b0;
    infl_last_d = 1'b0;
    if (issue_s) begin
      infl_err_d  = err_beat_s;
      infl_last_d = (issued_q == {1'b0, len_q});
    end else begin
      infl_err_d  = 1'b0;
      infl_last_d = 1'b0;
    end
  end

  // Control and pipe registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      arready_q   <= 1'b0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      fixed_q     <= 1'b0;
      err_cfg_q   <= 1'b0;
      issued_q    <= 9'd0;
      infl_q      <= 1'b0;
      infl_err_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      fixed_q     <= fixed_d;
      err_cfg_q   <= err_cfg_d;
      issued_q    <= issued_d;
      infl_q      <= infl_d;
      infl_err_q  <= infl_err_d;
      infl_last_q <= infl_last_d;
    end
  end

  // Output FIFO: capture memory data (or a SLVERR beat) from the pipe, release on R handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_resp_q[i] <= 2'b00;
        buf_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_s) begin
        buf_data_q[wr_ptr_q] <= infl_err_q ? {DATA_WIDTH{1'b0}} : mem_rdata;
        buf_resp_q[wr_ptr_q] <= infl_err_q ? 2'b10 : 2'b00;
        buf_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

endmodule

// File: tb/tb_axi4_mem_rd_ctrl.sv
// Directed testbench for axi4_mem_rd_ctrl with a behavioural 1-cycle memory.
module tb_axi4_mem_rd_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [15:0] ARADDR = 16'h0;
  logic [7:0]  ARLEN = 8'h0;
  logic [2:0]  ARSIZE = 3'b010;
  logic [1:0]  ARBURST = 2'b01;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID;
  logic        RREADY = 1'b0;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  int vec = 0;
  int mis = 0;
  int cyc = 0;

  always #5 ACLK = ~ACLK;

  axi4_mem_rd_ctrl dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_word(input int a);
    return {6'h2A, a[9:0], 6'h15, a[9:0]};
  endfunction

  always @(posedge ACLK) cyc <= cyc + 1;

  // memory: data valid the cycle after mem_en
  always @(posedge ACLK) if (mem_en) mem_rdata <= mem_word(int'(mem_addr));

  // monitor of memory reads and buffer occupancy
  int n_issue = 0, n_pop = 0, n_overfill = 0;
  int mon_addr [1024];
  int mon_cyc  [1024];
  always @(negedge ACLK) begin
    if (mem_en) begin
      if (n_issue - n_pop - ((RVALID && RREADY) ? 1 : 0) >= 2) n_overfill++;
      if (n_issue < 1024) begin
        mon_addr[n_issue] = int'(mem_addr);
        mon_cyc[n_issue]  = cyc;
      end
      n_issue++;
    end
    if (RVALID && RREADY) n_pop++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  int hs;
  bit ar_to;
  logic [31:0] b_data [16];
  logic [1:0]  b_resp [16];
  logic        b_last [16];
  int          b_cyc  [16];
  int nb, stall_viol;
  bit to_flag;

  task automatic send_ar(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    bit done = 1'b0;
    @(posedge ACLK); #1;
    ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b; ARVALID = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge ACLK);
      if (ARREADY) begin
        hs = cyc + 1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        done = 1'b1;
      end
    end
    ar_to = !done;
    ARVALID = 1'b0;
  endtask

  task automatic collect(input int n, input logic [7:0] pat, input int plen);
    int k = 0;
    bit held = 1'b0;
    logic [31:0] hd = 32'h0;
    logic [1:0]  hr = 2'b00;
    logic        hl = 1'b0;
    nb = 0; stall_viol = 0; to_flag = 1'b0;
    RREADY = pat[0];
    for (int c = 0; c < 200 && nb < n; c++) begin
      @(negedge ACLK);
      if (held && !(RVALID && RDATA == hd && RRESP == hr && RLAST == hl)) stall_viol++;
      held = RVALID && !RREADY;
      hd = RDATA; hr = RRESP; hl = RLAST;
      if (RVALID && RREADY) begin
        if (nb < 16) begin
          b_data[nb] = RDATA; b_resp[nb] = RRESP; b_last[nb] = RLAST; b_cyc[nb] = cyc;
        end
        nb++;
      end
      if (nb < n) begin
        @(posedge ACLK); #1;
        k++;
        RREADY = pat[k % plen];
      end
    end
    if (nb < n) to_flag = 1'b1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    vec++; if (ARREADY !== 1'b0) begin mis++; $display("FAIL rst_arready: got %b expected 0", ARREADY); end
    vec++; if (RVALID !== 1'b0) begin mis++; $display("FAIL rst_rvalid: got %b expected 0", RVALID); end
    vec++; if (RLAST !== 1'b0) begin mis++; $display("FAIL rst_rlast: got %b expected 0", RLAST); end
    vec++; if (RRESP !== 2'b00) begin mis++; $display("FAIL rst_rresp: got %b expected 00", RRESP); end
    vec++; if (RDATA !== 32'h0) begin mis++; $display("FAIL rst_rdata: got %h expected 0", RDATA); end
    vec++; if (mem_en !== 1'b0) begin mis++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
    vec++; if (mem_addr !== 10'd0) begin mis++; $display("FAIL rst_mem_addr: got %0d expected 0", mem_addr); end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    vec++; if (ARREADY !== 1'b0) begin mis++; $display("FAIL arready_before_edge: got %b expected 0", ARREADY); end
    @(negedge ACLK);
    vec++; if (ARREADY !== 1'b1) begin mis++; $display("FAIL arready_after_edge: got %b expected 1", ARREADY); end
  endtask

  task automatic test_single();
    int base = n_issue;
    send_ar(16'h0010, 8'd0, 3'b010, 2'b01);
    vec++; if (ar_to !== 1'b0) begin mis++; $display("FAIL single_ar: got timeout expected handshake"); end
    vec++; if (ARREADY !== 1'b0) begin mis++; $display("FAIL single_arready_low: got %b expected 0", ARREADY); end
    collect(1, 8'h01, 1);
    vec++; if (to_flag !== 1'b0) begin mis++; $display("FAIL single_r: got %0d beats expected 1", nb); end
    vec++; if (n_issue - base != 1) begin mis++; $display("FAIL single_nreads: got %0d expected 1", n_issue - base); end
    vec++; if (mon_addr[base] != 4) begin mis++; $display("FAIL single_mem_addr: got %0d expected 4", mon_addr[base]); end
    vec++; if (mon_cyc[base] != hs) begin mis++; $display("FAIL single_mem_en_cyc: got %0d expected %0d", mon_cyc[base], hs); end
    vec++; if (b_cyc[0] != hs + 2) begin mis++; $display("FAIL single_rvalid_cyc: got %0d expected %0d", b_cyc[0], hs + 2); end
    vec++; if (b_data[0] !== mem_word(4)) begin mis++; $display("FAIL single_rdata: got %h expected %h", b_data[0], mem_word(4)); end
    vec++; if (b_resp[0] !== 2'b00) begin mis++; $display("FAIL single_rresp: got %b expected 00", b_resp[0]); end
    vec++; if (b_last[0] !== 1'b1) begin mis++; $display("FAIL single_rlast: got %b expected 1", b_last[0]); end
    @(negedge ACLK);
    vec++; if (ARREADY !== 1'b1) begin mis++; $display("FAIL single_arready_back: got %b expected 1", ARREADY); end
  endtask

  task automatic test_back_to_back();
    int base = n_issue;
    send_ar(16'h0100, 8'd3, 3'b010, 2'b01);
    vec++; if (ar_to !== 1'b0) begin mis++; $display("FAIL b2b_ar: got timeout expected handshake"); end
    collect(4, 8'h01, 1);
    vec++; if (to_flag !== 1'b0) begin mis++; $display("FAIL b2b_r: got %0d beats expected 4", nb); end
    vec++; if (n_issue - base != 4) begin mis++; $display("FAIL b2b_nreads: got %0d expected 4", n_issue - base); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (mon_addr[base+i] != 64 + i) begin mis++; $display("FAIL b2b_mem_addr[%0d]: got %0d expected %0d", i, mon_addr[base+i], 64 + i); end
      vec++; if (mon_cyc[base+i] != hs + i) begin mis++; $display("FAIL b2b_mem_cyc[%0d]: got %0d expected %0d", i, mon_cyc[base+i], hs + i); end
      vec++; if (b_cyc[i] != hs + 2 + i) begin mis++; $display("FAIL b2b_beat_cyc[%0d]: got %0d expected %0d", i, b_cyc[i], hs + 2 + i); end
      vec++; if (b_data[i] !== mem_word(64 + i)) begin mis++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, b_data[i], mem_word(64 + i)); end
      vec++; if (b_last[i] !== (i == 3)) begin mis++; $display("FAIL b2b_rlast[%0d]: got %b expected %b", i, b_last[i], (i == 3)); end
    end
  endtask

  task automatic test_stall();
    int base = n_issue;
    int ov0 = n_overfill;
    int extra = 0;
    send_ar(16'h0100, 8'd3, 3'b010, 2'b01);
    vec++; if (ar_to !== 1'b0) begin mis++; $display("FAIL stall_ar: got timeout expected handshake"); end
    collect(4, 8'b0000_0001, 3);
    vec++; if (to_flag !== 1'b0) begin mis++; $display("FAIL stall_r: got %0d beats expected 4", nb); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (b_data[i] !== mem_word(64 + i)) begin mis++; $display("FAIL stall_rdata[%0d]: got %h expected %h", i, b_data[i], mem_word(64 + i)); end
      vec++; if (b_last[i] !== (i == 3)) begin mis++; $display("FAIL stall_rlast[%0d]: got %b expected %b", i, b_last[i], (i == 3)); end
    end
    vec++; if (stall_viol != 0) begin mis++; $display("FAIL stall_hold: got %0d changes expected 0", stall_viol); end
    vec++; if (n_overfill - ov0 != 0) begin mis++; $display("FAIL stall_overfill: got %0d expected 0", n_overfill - ov0); end
    vec++; if (n_issue - base != 4) begin mis++; $display("FAIL stall_nreads: got %0d expected 4", n_issue - base); end
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    repeat (4) begin
      @(negedge ACLK);
      if (RVALID) extra++;
    end
    vec++; if (extra != 0) begin mis++; $display("FAIL stall_extra_beats: got %0d expected 0", extra); end
  endtask

  task automatic test_fixed();
    int base = n_issue;
    send_ar(16'h0020, 8'd2, 3'b010, 2'b00);
    vec++; if (ar_to !== 1'b0) begin mis++; $display("FAIL fixed_ar: got timeout expected handshake"); end
    collect(3, 8'h01, 1);
    vec++; if (to_flag !== 1'b0) begin mis++; $display("FAIL fixed_r: got %0d beats expected 3", nb); end
    vec++; if (n_issue - base != 3) begin mis++; $display("FAIL fixed_nreads: got %0d expected 3", n_issue - base); end
    for (int i = 0; i < 3; i++) begin
      vec++; if (mon_addr[base+i] != 8) begin mis++; $display("FAIL fixed_mem_addr[%0d]: got %0d expected 8", i, mon_addr[base+i]); end
      vec++; if (b_data[i] !== mem_word(8)) begin mis++; $display("FAIL fixed_rdata[%0d]: got %h expected %h", i, b_data[i], mem_word(8)); end
      vec++; if (b_last[i] !== (i == 2)) begin mis++; $display("FAIL fixed_rlast[%0d]: got %b expected %b", i, b_last[i], (i == 2)); end
    end
  endtask

  task automatic test_err_cfg();
    logic [2:0] sz [2];
    logic [1:0] bt [2];
    sz[0] = 3'b010; bt[0] = 2'b10;
    sz[1] = 3'b001; bt[1] = 2'b01;
    for (int t = 0; t < 2; t++) begin
      int base = n_issue;
      send_ar(16'h0040, 8'd1, sz[t], bt[t]);
      vec++; if (ar_to !== 1'b0) begin mis++; $display("FAIL errcfg%0d_ar: got timeout expected handshake", t); end
      collect(2, 8'h01, 1);
      vec++; if (to_flag !== 1'b0) begin mis++; $display("FAIL errcfg%0d_r: got %0d beats expected 2", t, nb); end
      vec++; if (n_issue - base != 0) begin mis++; $display("FAIL errcfg%0d_mem_en: got %0d reads expected 0", t, n_issue - base); end
      for (int i = 0; i < 2; i++) begin
        vec++; if (b_data[i] !== 32'h0) begin mis++; $display("FAIL errcfg%0d_rdata[%0d]: got %h expected 0", t, i, b_data[i]); end
        vec++; if (b_resp[i] !== 2'b10) begin mis++; $display("FAIL errcfg%0d_rresp[%0d]: got %b expected 10", t, i, b_resp[i]); end
        vec++; if (b_last[i] !== (i == 1)) begin mis++; $display("FAIL errcfg%0d_rlast[%0d]: got %b expected %b", t, i, b_last[i], (i == 1)); end
      end
    end
  endtask

  task automatic test_out_of_range();
    int base = n_issue;
    logic [31:0] exp_d [4];
    logic [1:0]  exp_r [4];
    exp_d[0] = mem_word(1022); exp_d[1] = mem_word(1023); exp_d[2] = 32'h0; exp_d[3] = 32'h0;
    exp_r[0] = 2'b00; exp_r[1] = 2'b00; exp_r[2] = 2'b10; exp_r[3] = 2'b10;
    send_ar(16'h0FF8, 8'd3, 3'b010, 2'b01);
    vec++; if (ar_to !== 1'b0) begin mis++; $display("FAIL oob_ar: got timeout expected handshake"); end
    collect(4, 8'h01, 1);
    vec++; if (to_flag !== 1'b0) begin mis++; $display("FAIL oob_r: got %0d beats expected 4", nb); end
    vec++; if (n_issue - base != 2) begin mis++; $display("FAIL oob_nreads: got %0d expected 2", n_issue - base); end
    vec++; if (mon_addr[base] != 1022) begin mis++; $display("FAIL oob_mem_addr0: got %0d expected 1022", mon_addr[base]); end
    vec++; if (mon_addr[base+1] != 1023) begin mis++; $display("FAIL oob_mem_addr1: got %0d expected 1023", mon_addr[base+1]); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (b_data[i] !== exp_d[i]) begin mis++; $display("FAIL oob_rdata[%0d]: got %h expected %h", i, b_data[i], exp_d[i]); end
      vec++; if (b_resp[i] !== exp_r[i]) begin mis++; $display("FAIL oob_rresp[%0d]: got %b expected %b", i, b_resp[i], exp_r[i]); end
      vec++; if (b_last[i] !== (i == 3)) begin mis++; $display("FAIL oob_rlast[%0d]: got %b expected %b", i, b_last[i], (i == 3)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    RREADY = 1'b1;
    send_ar(16'h0100, 8'd7, 3'b010, 2'b01);
    vec++; if (ar_to !== 1'b0) begin mis++; $display("FAIL rstmid_ar: got timeout expected handshake"); end
    repeat (3) @(negedge ACLK);
    vec++; if (mem_en !== 1'b1) begin mis++; $display("FAIL rstmid_pre_mem_en: got %b expected 1", mem_en); end
    vec++; if (RVALID !== 1'b1) begin mis++; $display("FAIL rstmid_pre_rvalid: got %b expected 1", RVALID); end
    #1 ARESETn = 1'b0;
    #1;
    vec++; if (RVALID !== 1'b0) begin mis++; $display("FAIL rstmid_rvalid: got %b expected 0", RVALID); end
    vec++; if (mem_en !== 1'b0) begin mis++; $display("FAIL rstmid_mem_en: got %b expected 0", mem_en); end
    vec++; if (ARREADY !== 1'b0) begin mis++; $display("FAIL rstmid_arready: got %b expected 0", ARREADY); end
    vec++; if (RLAST !== 1'b0) begin mis++; $display("FAIL rstmid_rlast: got %b expected 0", RLAST); end
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    send_ar(16'h0010, 8'd0, 3'b010, 2'b01);
    vec++; if (ar_to !== 1'b0) begin mis++; $display("FAIL rstmid_post_ar: got timeout expected handshake"); end
    collect(1, 8'h01, 1);
    vec++; if (to_flag !== 1'b0) begin mis++; $display("FAIL rstmid_post_r: got %0d beats expected 1", nb); end
    vec++; if (b_data[0] !== mem_word(4)) begin mis++; $display("FAIL rstmid_post_rdata: got %h expected %h", b_data[0], mem_word(4)); end
    vec++; if (b_resp[0] !== 2'b00) begin mis++; $display("FAIL rstmid_post_rresp: got %b expected 00", b_resp[0]); end
    vec++; if (b_last[0] !== 1'b1) begin mis++; $display("FAIL rstmid_post_rlast: got %b expected 1", b_last[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_fixed();
    test_err_cfg();
    test_out_of_range();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/axi4_mem_rd_ctrl.md
Name: axi4_mem_rd_ctrl

Overview:
AXI4 read-channel front-end for the on-chip 1024x32 word memory. It accepts one AR burst at a time and converts it into single-word memory reads on the mem_en/mem_addr/mem_rdata port. It returns the beats on the R channel through a 2-entry output buffer, sustaining one beat per cycle while RREADY is high. It sits directly upstream of the memory and drives that memory's read side; the write path arbitrates separately for mem_we/mem_wdata.

Parameters:
ADDR_WIDTH, 16, AXI byte-address width
DATA_WIDTH, 32, AXI and memory data width
MEM_DEPTH, 1024, memory depth in words
MEM_ADDR_WIDTH, 10, memory word-address width (log2 MEM_DEPTH)

Ports:
ACLK  in  1  clock, rising edge
ARESETn  in  1  asynchronous active-low reset
ARADDR  in  ADDR_WIDTH  burst start byte address
ARLEN  in  8  beats minus 1
ARSIZE  in  3  beat size; only 3'b010 is legal
ARBURST  in  2  00 FIXED, 01 INCR, others unsupported
ARVALID  in  1  AR valid
ARREADY  out  1  AR ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RLAST  out  1  final beat of burst
RVALID  out  1  R valid
RREADY  in  1  R ready
mem_en  out  1  memory read strobe
mem_addr  out  MEM_ADDR_WIDTH  memory word address
mem_rdata  in  DATA_WIDTH  memory data, valid 1 cycle after mem_en

Behaviour:
- Clocking and reset: single clock ACLK. ARESETn asynchronous, active-low.
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RRESP=00, RDATA=0, mem_en=0, mem_addr=0. Buffer, counters and in-flight flag are cleared; state is IDLE.
- ARREADY is registered. It rises on the first ACLK edge after reset release and is high only in IDLE.
- FSM IDLE: on ARVALID&ARREADY, latch addr, len, burst, and err_cfg = (ARSIZE!=010) | (ARBURST[1]==1). Go to BURST; ARREADY drops on the same edge.
- FSM BURST: issue beats, beat_cnt 0..len. Leave when the final beat (RLAST) completes its RVALID&RREADY handshake; return to IDLE and re-raise ARREADY on that edge.
- Issue rule: a beat may be issued in a cycle only if (buf_count + inflight - pop) < 2, where pop = RVALID&RREADY in that cycle. No buffer overflow is permitted.
- Beat error: err_beat = err_cfg | (byte address >= MEM_DEPTH*4).
  - Error beats do not assert mem_en.
  - They still occupy the 1-cycle pipe so beat order is preserved.
  - They enter the buffer with RDATA=0 and RRESP=10.
- OK beats: mem_en=1 and mem_addr=addr[MEM_ADDR_WIDTH+1:2]. mem_rdata is captured into the buffer on the next edge with RRESP=00.
- Address update after each issued beat: INCR adds 4; FIXED holds. ARADDR[1:0] is ignored (forced word aligned). A burst that runs past the end of memory returns SLVERR for every beat beyond it, with no wrap.
- Latency: AR handshake at edge E0 gives mem_en high in cycle E0..E1 and RVALID high from edge E2. With RREADY held at 1, beats are back-to-back.
- RLAST=1 exactly on the beat with index len. ARLEN=0 gives a single beat with RLAST=1.
- R outputs are stable while RVALID=1 and RREADY=0 (AXI rule). RVALID never drops without a handshake.
- Buffer is 2-entry FIFO, first-word-fall-through to the R outputs. Simultaneous push and pop in the same cycle is legal and leaves the count unchanged.
- ARVALID while in BURST is ignored; the AR is held by the master until IDLE.
- Reset asserted mid-burst: all outputs go to their reset values immediately (asynchronous). Remaining beats are discarded; no RLAST is issued.

Test Plan:
1. ARADDR=0x0010, ARLEN=0, INCR, RREADY=1 -> mem_addr=4; RVALID at E2 with RDATA=mem[4], RRESP=00, RLAST=1; ARREADY high again the cycle after the handshake.
2. ARADDR=0x0100, ARLEN=3, INCR, RREADY=1 -> mem_addr 64,65,66,67 on consecutive cycles; 4 back-to-back beats, RLAST only on the 4th.
3. Same burst with RREADY toggling 1,0,0,1,... -> no beat lost or duplicated; RDATA/RLAST held while stalled; mem_en never issues with the buffer full.
4. ARADDR=0x0020, ARLEN=2, FIXED -> mem_addr=8 three times; three beats all equal to mem[8].
5. ARBURST=10 (WRAP), ARLEN=1 -> no mem_en; 2 beats with RDATA=0, RRESP=10, RLAST on the 2nd. Repeat with ARSIZE=001 -> same result.
6. ARADDR=0x0FF8, ARLEN=3, INCR -> beats 0-1 OKAY from mem[1022], mem[1023]; beats 2-3 SLVERR with no mem_en. Separately, ARESETn low mid-burst -> RVALID/mem_en/ARREADY drop to 0 at once; after release, a new single-beat read completes correctly.
